neuron_accum: RTL

Sequential multiply-accumulate producer for one neuron of the network datapath. Consumes N_INPUTS (activation, weight) pairs over a valid/ready stream, adds them to a bias, and presents the 12-bit signed pre-activation sum on a valid/ready output. The activation stage that turns a 12-bit sum into a 5-bit activation sits downstream of this block. This block is the producing end of that 12-bit interface.

---
 rtl/neuron_accum.sv | 115 +++++++++++
 1 files changed

// File: rtl/neuron_accum.sv
// Sequential multiply-accumulate for one neuron: bias plus N_INPUTS signed products over a
// valid/ready stream. Define SATURATE_EN to clamp each addition; otherwise additions wrap.
module neuron_accum #(
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned ACT_W    = 5,
    parameter int unsigned ACC_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACT_W-1:0] act_in,
    input  logic [ACT_W-1:0] w_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic             busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PROD_W = 2 * ACT_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

    logic [1:0]              r_state;
    logic [1:0]              w_state_d;
    logic [ACC_W-1:0]        r_acc;
    logic [ACC_W-1:0]        w_acc_d;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_d;
    logic signed [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]        w_prod_ext;
    logic [ACC_W-1:0]        w_sum;
    logic [ACC_W-1:0]        w_next_acc;
    logic                    w_beat;

    assign w_prod     = $signed(act_in) * $signed(w_in);
    assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;

`ifdef SATURATE_EN
    logic w_ovf;

    // Overflow only when both operands share a sign that the result does not.
    assign w_ovf = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                   (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

    always_comb begin
        w_next_acc = w_sum;
        if (w_ovf) begin
            w_next_acc = r_acc[ACC_W-1] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                        : {1'b0, {(ACC_W - 1){1'b1}}};
        end
    end
`else
    assign w_next_acc = w_sum;
`endif

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign sum_out   = r_acc;
    assign w_beat    = in_valid && in_ready;

    always_comb begin
        w_state_d = r_state;
        w_acc_d   = r_acc;
        w_cnt_d   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_d = ST_ACCUM;
                    w_acc_d   = bias;
                    w_cnt_d   = '0;
                end
            end
            ST_ACCUM: begin
                if (w_beat) begin
                    w_acc_d = w_next_acc;
                    w_cnt_d = r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_acc   <= w_acc_d;
            r_cnt   <= w_cnt_d;
        end
    end

endmodule
